// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle CPU: stage codes, PC source
// selects and instruction field positions.
package cpu_defs;

  typedef enum logic [2:0] {
    IF_STAGE  = 3'd0,
    ID_STAGE  = 3'd1,
    EX_STAGE  = 3'd2,
    MEM_STAGE = 3'd3,
    WB_STAGE  = 3'd4
  } stage_e;

  typedef enum logic [1:0] {
    PCSRC_INC    = 2'd0,
    PCSRC_JUMP   = 2'd1,
    PCSRC_BRANCH = 2'd2,
    PCSRC_RSVD   = 2'd3
  } pc_src_e;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned MODE_MSB   = 1;
  localparam int unsigned MODE_LSB   = 0;

  // Codes 5..7 do not name a stage.
  function automatic logic is_legal_stage(input logic [2:0] s);
    return (s <= 3'd4);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// Watchdog counter for stalled IF/MEM cycles. Counts stalled cycles,
// clears on any advance, and raises o_expire on the stalled cycle that
// would bring the count to TIMEOUT. TIMEOUT==0 disables expiry.
module stall_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stall,
  input  logic i_clear,
  output logic o_expire
);

  // Count value seen during the TIMEOUT-th stalled cycle.
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Expire is combinational so the abort lands on the same edge as the
  // TIMEOUT-th stalled cycle; the counter itself never holds TIMEOUT.
  always_comb begin
    o_expire = (TIMEOUT != 0) && i_stall && (r_cnt == LAST);
  end

  // Saturating stall counter, cleared on advance or on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_expire) begin
      r_cnt <= '0;
    end else if (i_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Sequential partner of ControlUnit: stage register, PC, instruction
// register and flag register, with memory-handshake stalls and a watchdog.
module stage_sequencer
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  next_state,
  input  logic [1:0]  PC_src,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_neg,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [1:0]  mode,
  output logic        zeroFlag,
  output logic        carryFlag,
  output logic        negFlag,
  output logic        stage_adv,
  output logic        retired,
  output logic        illegal_state,
  output logic        timeout_err
);

  stage_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_zero, r_carry, r_neg;
  logic        r_stage_adv, r_retired, r_illegal, r_timeout;

  logic        w_adv, w_stall, w_expire, w_illegal, w_in_ex;
  logic [31:0] w_pc_inc, w_pc_next;

  // Advance/stall decision and next-PC selection.
  always_comb begin
    w_adv = 1'b1;
    case (r_state)
      IF_STAGE:  w_adv = imem_valid;
      MEM_STAGE: w_adv = dmem_ready || !(dmem_read || dmem_write);
      default:   w_adv = 1'b1;
    endcase
    w_stall   = ((r_state == IF_STAGE) || (r_state == MEM_STAGE)) && !w_adv;
    w_illegal = !is_legal_stage(next_state);
    w_pc_inc  = r_pc + 32'd1;
    case (pc_src_e'(PC_src))
      PCSRC_JUMP:   w_pc_next = jump_target;
      PCSRC_BRANCH: w_pc_next = branch_target;
      default:      w_pc_next = w_pc_inc;
    endcase
  end

  stall_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_stall_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_stall  (w_stall),
    .i_clear  (w_adv),
    .o_expire (w_expire)
  );

  // Stage/PC/IR/flag registers. A normal advance always wins over the
  // watchdog because expiry is only possible on a stalled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IF_STAGE;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_neg       <= 1'b0;
      r_stage_adv <= 1'b0;
      r_retired   <= 1'b0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_stage_adv <= w_adv;
      r_retired   <= 1'b0;
      if (w_adv) begin
        if (r_state == IF_STAGE) begin
          r_instr <= imem_data;
        end
        if (r_state == EX_STAGE) begin
          r_zero  <= alu_zero;
          r_carry <= alu_carry;
          r_neg   <= alu_neg;
        end
        if (w_illegal) begin
          r_state   <= IF_STAGE;
          r_pc      <= w_pc_inc;
          r_illegal <= 1'b1;
        end else begin
          r_state <= stage_e'(next_state);
          if ((r_state != IF_STAGE) && (next_state == IF_STAGE)) begin
            r_pc      <= w_pc_next;
            r_retired <= 1'b1;
          end
        end
      end else if (w_expire) begin
        r_state   <= IF_STAGE;
        r_pc      <= w_pc_inc;
        r_timeout <= 1'b1;
      end
    end
  end

  // Outputs; in EX the flags are live so the branch decision sees them.
  always_comb begin
    w_in_ex       = (r_state == EX_STAGE);
    state         = r_state;
    pc            = r_pc;
    imem_req      = (r_state == IF_STAGE);
    instr         = r_instr;
    opcode        = r_instr[OPCODE_MSB:OPCODE_LSB];
    mode          = r_instr[MODE_MSB:MODE_LSB];
    zeroFlag      = w_in_ex ? alu_zero  : r_zero;
    carryFlag     = w_in_ex ? alu_carry : r_carry;
    negFlag       = w_in_ex ? alu_neg   : r_neg;
    stage_adv     = r_stage_adv;
    retired       = r_retired;
    illegal_state = r_illegal;
    timeout_err   = r_timeout;
  end

endmodule
